// File: rtl/uart_rx_fifo.sv
// Purpose: receive-side byte FIFO behind the UART RX deserializer, with a first-word-fall-through (FWFT) read port.
// Latency: a byte is visible on RD_DATA/COUNT right after the edge that sees the RX_END rising edge.
// Backpressure: none toward RX; a write into a full FIFO is dropped and sets sticky OVERRUN.
module uart_rx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX_END,
    input  logic [WIDTH-1:0] DQ,
    input  logic             RD,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             EMPTY,
    output logic             FULL,
    output logic [CW-1:0]    COUNT,
    output logic             OVERRUN,
    input  logic             OVR_CLR
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overrun;
    logic             rx_end_q;
    logic             wr_evt;
    logic             pop;
    logic             do_wr;
    logic             drop;

    assign wr_evt = RX_END & ~rx_end_q;
    assign pop    = RD & ~EMPTY;
    // When full, a simultaneous pop frees the slot being written, so the write may proceed.
    assign do_wr  = wr_evt & (~FULL | pop);
    assign drop   = wr_evt & FULL & ~pop;

    assign EMPTY   = (count == '0);
    assign FULL    = (count == CW'(DEPTH));
    assign COUNT   = count;
    assign OVERRUN = overrun;
    assign RD_DATA = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            rx_end_q <= 1'b1;
        end else begin
            rx_end_q <= RX_END;
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overrun <= 1'b1;
            end else if (OVR_CLR) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= DQ;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed stimulus for uart_rx_fifo; a negedge monitor compares the DUT against a queue-based model.
module tb_uart_rx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             RX_END = 1'b0;
    logic [WIDTH-1:0] DQ = '0;
    logic             RD = 1'b0;
    logic [WIDTH-1:0] RD_DATA;
    logic             EMPTY;
    logic             FULL;
    logic [CW-1:0]    COUNT;
    logic             OVERRUN;
    logic             OVR_CLR = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             m_ovr  = 1'b0;
    logic             m_prev = 1'b1;

    uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .RX_END(RX_END), .DQ(DQ), .RD(RD),
        .RD_DATA(RD_DATA), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
        .OVERRUN(OVERRUN), .OVR_CLR(OVR_CLR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // The model advances on the falling edge using the inputs the next rising edge will see.
    always @(negedge clk) begin
        int  sz;
        bit  wr, pp, dropped;
        if (rst) begin
            exp_q.delete();
            m_ovr  = 1'b0;
            m_prev = 1'b1;
            chk("count_in_reset", 32'(COUNT), 0);
        end else begin
            sz = exp_q.size();
            chk("count", 32'(COUNT), 32'(sz));
            chk("empty", 32'(EMPTY), 32'(sz == 0));
            chk("full", 32'(FULL), 32'(sz == DEPTH));
            chk("overrun", 32'(OVERRUN), 32'(m_ovr));
            pp = RD && (sz > 0);
            if (pp) chk("rd_data", 32'(RD_DATA), 32'(exp_q.pop_front()));
            wr      = RX_END && !m_prev;
            m_prev  = RX_END;
            dropped = wr && (sz == DEPTH) && !pp;
            if (wr && !dropped) exp_q.push_back(DQ);
            if (dropped) m_ovr = 1'b1;
            else if (OVR_CLR) m_ovr = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [WIDTH-1:0] d);
        RX_END = 1'b1; DQ = d;
        step();
        RX_END = 1'b0;
        step();
    endtask

    task automatic pop_n(input int n);
        RD = 1'b1;
        repeat (n) step();
        RD = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_empty", 32'(EMPTY), 1);
        chk("rst_full", 32'(FULL), 0);
        chk("rst_overrun", 32'(OVERRUN), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Three single writes, then drain in order.
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
        chk("t1_count", 32'(COUNT), 3);
        chk("t1_head", 32'(RD_DATA), 32'h11);
        pop_n(3);
        chk("t1_empty", 32'(EMPTY), 1);

        // A long RX_END level is one write.
        RX_END = 1'b1; DQ = 8'hA5;
        repeat (5) step();
        RX_END = 1'b0;
        step();
        chk("t2_count", 32'(COUNT), 1);
        pop_n(1);

        // Overfill by one; the 17th byte is dropped.
        for (int i = 0; i <= DEPTH; i++) wr_byte(8'(i));
        chk("t3_full", 32'(FULL), 1);
        chk("t3_overrun", 32'(OVERRUN), 1);
        chk("t3_count", 32'(COUNT), DEPTH);
        OVR_CLR = 1'b1; step(); OVR_CLR = 1'b0;
        chk("t3_ovr_clr", 32'(OVERRUN), 0);

        // Full FIFO: simultaneous write and pop is not an overrun.
        RX_END = 1'b1; DQ = 8'h5A; RD = 1'b1;
        step();
        RX_END = 1'b0; RD = 1'b0;
        step();
        chk("t4_count", 32'(COUNT), DEPTH);
        chk("t4_overrun", 32'(OVERRUN), 0);
        pop_n(DEPTH);
        chk("t4_empty", 32'(EMPTY), 1);

        // Empty FIFO: RD alongside a write only writes.
        RX_END = 1'b1; DQ = 8'h77; RD = 1'b1;
        step();
        RX_END = 1'b0; RD = 1'b0;
        step();
        chk("t5_count", 32'(COUNT), 1);
        chk("t5_head", 32'(RD_DATA), 32'h77);
        for (int i = 1; i < DEPTH; i++) wr_byte(8'($urandom));
        chk("t5_full", 32'(FULL), 1);
        RX_END = 1'b1; DQ = 8'hEE; OVR_CLR = 1'b1;
        step();
        RX_END = 1'b0; OVR_CLR = 1'b0;
        step();
        chk("t5_set_wins", 32'(OVERRUN), 1);
        pop_n(DEPTH);

        // Pointer wrap with interleaved writes and pops.
        wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
        for (int i = 0; i < 40; i++) begin
            wr_byte(8'($urandom));
            pop_n(1);
        end
        pop_n(3);
        chk("t6_empty", 32'(EMPTY), 1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if (!RX_END) DQ = 8'($urandom);
            RX_END  = ($urandom_range(0, 2) == 0);
            RD      = ($urandom_range(0, 3) == 0);
            OVR_CLR = ($urandom_range(0, 19) == 0);
            step();
        end
        RD = 1'b0; OVR_CLR = 1'b0;

        // Reset mid-stream with RX_END held high.
        RX_END = 1'b1; DQ = 8'h3C;
        step();
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_count", 32'(COUNT), 0);
        chk("t6_rst_empty", 32'(EMPTY), 1);
        chk("t6_rst_overrun", 32'(OVERRUN), 0);
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("t6_no_write_high", 32'(COUNT), 0);
        RX_END = 1'b0; step();
        RX_END = 1'b1; DQ = 8'hC3; step();
        RX_END = 1'b0; step();
        chk("t6_rewrite_count", 32'(COUNT), 1);
        chk("t6_rewrite_head", 32'(RD_DATA), 32'hC3);
        pop_n(1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
